// File: rtl/echo_distance_meter.sv
// Echo pulse width to centimetres in 1 us ticks: result registered on the edge entering DONE,
// fall acted on 3 clk after the pin; no backpressure, one valid strobe per enable window.
module echo_distance_meter #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int US_PER_CM  = 58,
    parameter int MAX_CM     = 400,
    parameter int TIMEOUT_US = 30000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       echo,
    output logic [8:0] distance_cm,
    output logic       valid,
    output logic       timeout,
    output logic       over_range,
    output logic       busy
);

    localparam int TICKS_PER_US = CLK_HZ / 1000000;
    localparam int PW = (TICKS_PER_US > 2) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_US - 1);
    localparam logic [5:0]    SUB_MAX   = 6'(US_PER_CM - 1);
    localparam logic [8:0]    CM_MAX    = 9'(MAX_CM);
    localparam logic [14:0]   WAIT_MAX  = 15'(TIMEOUT_US);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RISE,
        S_MEASURE,
        S_DONE,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          echo_d_q, echo_d_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [14:0]   wait_us_q, wait_us_d;
    logic [5:0]    sub_cm_q, sub_cm_d;
    logic [8:0]    cm_cnt_q, cm_cnt_d;
    logic [8:0]    dist_q, dist_d;
    logic          valid_q, valid_d;
    logic          tmo_q, tmo_d;
    logic          ovr_q, ovr_d;

    logic tick, rise, fall;

    assign tick = (presc_q == PRESC_MAX);
    assign rise = sync2_q & ~echo_d_q;
    assign fall = ~sync2_q & echo_d_q;

    always_comb begin
        state_d   = state_q;
        sync1_d   = echo;
        sync2_d   = sync1_q;
        echo_d_d  = sync2_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        wait_us_d = wait_us_q;
        sub_cm_d  = sub_cm_q;
        cm_cnt_d  = cm_cnt_q;
        dist_d    = dist_q;
        valid_d   = 1'b0;
        tmo_d     = tmo_q;
        ovr_d     = ovr_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d   = S_WAIT_RISE;
                    presc_d   = '0;
                    wait_us_d = '0;
                    sub_cm_d  = '0;
                    cm_cnt_d  = '0;
                end
            end
            S_WAIT_RISE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    state_d  = S_MEASURE;
                    presc_d  = '0;
                    sub_cm_d = '0;
                    cm_cnt_d = '0;
                end else if (tick) begin
                    wait_us_d = wait_us_q + 15'd1;
                    if (wait_us_d == WAIT_MAX) begin
                        state_d = S_DONE;
                        dist_d  = '0;
                        tmo_d   = 1'b1;
                        ovr_d   = 1'b0;
                        valid_d = 1'b1;
                    end
                end
            end
            S_MEASURE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    if (tick) begin
                        if (sub_cm_q == SUB_MAX) begin
                            sub_cm_d = '0;
                            cm_cnt_d = cm_cnt_q + 9'd1;
                        end else begin
                            sub_cm_d = sub_cm_q + 6'd1;
                        end
                    end
                    // A microsecond completing on the fall edge still belongs to the pulse.
                    if (fall) begin
                        state_d = S_DONE;
                        dist_d  = cm_cnt_d;
                        tmo_d   = 1'b0;
                        ovr_d   = 1'b0;
                        valid_d = 1'b1;
                    end else if (cm_cnt_d == CM_MAX) begin
                        state_d = S_DONE;
                        dist_d  = CM_MAX;
                        tmo_d   = 1'b0;
                        ovr_d   = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            echo_d_q  <= 1'b0;
            presc_q   <= '0;
            wait_us_q <= '0;
            sub_cm_q  <= '0;
            cm_cnt_q  <= '0;
            dist_q    <= '0;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            echo_d_q  <= echo_d_d;
            presc_q   <= presc_d;
            wait_us_q <= wait_us_d;
            sub_cm_q  <= sub_cm_d;
            cm_cnt_q  <= cm_cnt_d;
            dist_q    <= dist_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
            ovr_q     <= ovr_d;
        end
    end

    assign distance_cm = dist_q;
    assign valid       = valid_q;
    assign timeout     = tmo_q;
    assign over_range  = ovr_q;
    assign busy        = (state_q == S_WAIT_RISE) || (state_q == S_MEASURE);

endmodule

// File: tb/tb_echo_distance_meter.sv
// Bench for echo_distance_meter at 2 ticks/us with scaled MAX_CM/TIMEOUT_US; results
// are queued at stimulus time and checked by an independent monitor on every valid.
`timescale 1ns/1ps
module tb_echo_distance_meter;

    localparam int T          = 2;
    localparam int MAX_CM     = 110;
    localparam int TIMEOUT_US = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       echo;
    logic [8:0] distance_cm;
    logic       valid;
    logic       timeout;
    logic       over_range;
    logic       busy;

    typedef struct {
        int d;
        int t;
        int o;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   total = 0;
    int   bad   = 0;
    logic prev_valid = 1'b0;

    echo_distance_meter #(
        .CLK_HZ    (T * 1000000),
        .US_PER_CM (58),
        .MAX_CM    (MAX_CM),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .echo       (echo),
        .distance_cm(distance_cm),
        .valid      (valid),
        .timeout    (timeout),
        .over_range (over_range),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic expect_result(input int d, input int t, input int o);
        exp_t e;
        e.d = d;
        e.t = t;
        e.o = o;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic window(input int pre_us, input int high_us, input int post_us);
        enable = 1'b1;
        cyc(pre_us * T);
        echo = 1'b1;
        cyc(high_us * T);
        echo = 1'b0;
        cyc(post_us * T);
        enable = 1'b0;
        cyc(4);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            chk("valid_back_to_back", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e_mon = exp_q.pop_front();
                chk("distance_cm", int'(distance_cm), e_mon.d);
                chk("timeout", int'(timeout), e_mon.t);
                chk("over_range", int'(over_range), e_mon.o);
            end
        end
        prev_valid = valid;
    end

    initial begin
        int k;
        reset  = 1'b1;
        enable = 1'b0;
        echo   = 1'b0;
        cyc(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_distance", int'(distance_cm), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_over_range", int'(over_range), 0);
        chk("rst_busy", int'(busy), 0);

        // Nominal 580 us pulse, with valid latency measured from the pin fall.
        expect_result(10, 0, 0);
        enable = 1'b1;
        cyc(100 * T);
        @(negedge clk);
        chk("busy_wait_rise", int'(busy), 1);
        echo = 1'b1;
        cyc(580 * T);
        echo = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (valid) break;
        end
        chk("valid_latency_edges", k, 3);
        cyc(10);
        @(negedge clk);
        chk("busy_hold", int'(busy), 0);
        enable = 1'b0;
        cyc(4);

        expect_result(1, 0, 0);
        window(50, 115, 20);
        expect_result(100, 0, 0);
        window(50, 5800, 20);

        // Echo outlasts MAX_CM; the late fall must not give a second result.
        expect_result(MAX_CM, 0, 1);
        window(50, 7000, 20);
        @(negedge clk);
        chk("over_range_held", int'(over_range), 1);
        chk("distance_sat_held", int'(distance_cm), MAX_CM);

        expect_result(0, 1, 0);
        enable = 1'b1;
        cyc((TIMEOUT_US + 50) * T);
        enable = 1'b0;
        cyc(4);
        @(negedge clk);
        chk("timeout_held", int'(timeout), 1);

        // Echo rising shortly before the timeout still measures.
        expect_result(1, 0, 0);
        window(TIMEOUT_US - 10, 58, 20);

        expect_result(10, 0, 0);
        window(100, 580, 20);
        @(negedge clk);
        chk("timeout_cleared", int'(timeout), 0);

        // Abort mid-pulse: no result, previous distance retained.
        enable = 1'b1;
        cyc(50 * T);
        echo = 1'b1;
        cyc(200 * T);
        enable = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        echo = 1'b0;
        cyc(20);
        @(negedge clk);
        chk("abort_distance_kept", int'(distance_cm), 10);

        // Reset in the middle of MEASURE.
        enable = 1'b1;
        cyc(20 * T);
        echo = 1'b1;
        cyc(100 * T);
        reset = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("mid_rst_distance", int'(distance_cm), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_timeout", int'(timeout), 0);
        chk("mid_rst_over_range", int'(over_range), 0);
        chk("mid_rst_busy", int'(busy), 0);
        enable = 1'b0;
        echo   = 1'b0;
        reset  = 1'b0;
        cyc(100);
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
